// File: rtl/shift_reg_pkg.sv
// shift_reg_pkg: opcode and FSM state encodings shared by the universal shift register
package shift_reg_pkg;
  typedef enum logic [2:0] {
    OP_HOLD, OP_CLEAR, OP_LOAD, OP_SHL, OP_SHR, OP_ROL, OP_ROR, OP_ASR
  } op_e;
  typedef enum logic {ST_IDLE, ST_SHIFTING} state_e;
endpackage

// File: rtl/shift_reg_step.sv
// shift_reg_step: combinational one-position shift/rotate unit
//   value/opcode/serial_in -> next_value, out_bit (bit leaving, or wrapping, for rotates)
module shift_reg_step
  import shift_reg_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  op_e              opcode,
  input  logic             serial_in,
  output logic [WIDTH-1:0] next_value,
  output logic             out_bit
);
  assign next_value = opcode == OP_SHL ? {value[WIDTH-2:0], serial_in} :
                      opcode == OP_ROL ? {value[WIDTH-2:0], value[WIDTH-1]} :
                      opcode == OP_SHR ? {serial_in, value[WIDTH-1:1]} :
                      opcode == OP_ROR ? {value[0], value[WIDTH-1:1]} :
                      opcode == OP_ASR ? {value[WIDTH-1], value[WIDTH-1:1]} : value;
  assign out_bit = (opcode == OP_SHL || opcode == OP_ROL) ? value[WIDTH-1] : value[0];
endmodule

// File: rtl/shift_reg_universal.sv
// shift_reg_universal: parametrised universal shift register with multi-step shift commands
//   cmd_valid/cmd_ready/funcao/quant/entrada: command handshake, opcode, amount, load data
//   serial_in: fill bit for SHL/SHR; valor/serial_out: contents and last bit out
//   busy: multi-step shift in progress; done: one-cycle completion pulse
module shift_reg_universal
  import shift_reg_pkg::*;
#(
  parameter  int               WIDTH       = 8,
  parameter  logic [WIDTH-1:0] RESET_VALUE = '0,
  localparam int               CNT_W       = $clog2(WIDTH + 1)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       funcao,
  input  logic [CNT_W-1:0] quant,
  input  logic [WIDTH-1:0] entrada,
  input  logic             serial_in,
  output logic [WIDTH-1:0] valor,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);
  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] valor_q, valor_d, step_val;
  logic             sout_q, sout_d, done_q, done_d, step_bit;
  op_e              op_in;
  assign op_in = op_e'(funcao);
  // The step unit sees the incoming opcode on the accept edge, the latched one afterwards.
  shift_reg_step #(.WIDTH(WIDTH)) u_step (
    .value     (valor_q),
    .opcode    (state_q == ST_IDLE ? op_in : op_q),
    .serial_in (serial_in),
    .next_value(step_val),
    .out_bit   (step_bit)
  );
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rem_d   = rem_q;
    valor_d = valor_q;
    sout_d  = sout_q;
    done_d  = 1'b0;
    if (state_q == ST_SHIFTING) begin
      valor_d = step_val;
      sout_d  = step_bit;
      rem_d   = rem_q - 1'b1;
      if (rem_q == CNT_W'(1)) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end
    end else if (cmd_valid) begin
      op_d = op_in;
      if (op_in < OP_SHL) begin
        valor_d = op_in == OP_CLEAR ? '0 : op_in == OP_LOAD ? entrada : valor_q;
        done_d  = 1'b1;
      end else if (quant == '0) begin
        done_d = 1'b1;
      end else begin
        valor_d = step_val;
        sout_d  = step_bit;
        if (quant == CNT_W'(1)) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_SHIFTING;
          rem_d   = quant - 1'b1;
        end
      end
    end
  end
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_q    <= OP_HOLD;
      rem_q   <= '0;
      valor_q <= RESET_VALUE;
      sout_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rem_q   <= rem_d;
      valor_q <= valor_d;
      sout_q  <= sout_d;
      done_q  <= done_d;
    end
  end
  assign valor      = valor_q;
  assign serial_out = sout_q;
  assign busy       = state_q == ST_SHIFTING;
  assign cmd_ready  = !busy;
  assign done       = done_q;
endmodule

// File: tb/tb_shift_reg_universal.sv
// tb_shift_reg_universal: directed self-checking bench for shift_reg_universal (WIDTH=8)
module tb_shift_reg_universal;
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] funcao = 3'd0;
  logic [3:0] quant = 4'd0;
  logic [7:0] entrada = 8'h00;
  logic       serial_in = 1'b0;
  logic [7:0] valor;
  logic       serial_out, busy, done;
  int         total = 0;
  int         bad = 0;
  logic [7:0] exp_v;

  shift_reg_universal #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clock(clk), .reset_n(reset_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .funcao(funcao), .quant(quant), .entrada(entrada), .serial_in(serial_in),
    .valor(valor), .serial_out(serial_out), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a command for exactly one rising edge; returns at the following falling edge.
  task automatic issue(input logic [2:0] op, input logic [3:0] q, input logic [7:0] d, input logic si);
    funcao = op; quant = q; entrada = d; serial_in = si; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_valor", valor, 8'h00);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_sout", serial_out, 0);
    chk("rst_ready", cmd_ready, 1);
    reset_n = 1'b1;
    // LOAD 0xA5
    issue(3'd2, 4'd3, 8'hA5, 1'b0);
    chk("load_valor", valor, 8'hA5);
    chk("load_done", done, 1);
    chk("load_busy", busy, 0);
    @(negedge clk);
    chk("load_done_drop", done, 0);
    // SHL by 3 with serial_in=1
    issue(3'd3, 4'd3, 8'h00, 1'b1);
    chk("shl_s1", valor, 8'h4B);
    chk("shl_busy1", busy, 1);
    chk("shl_ready1", cmd_ready, 0);
    chk("shl_nodone1", done, 0);
    @(negedge clk);
    chk("shl_s2", valor, 8'h97);
    chk("shl_busy2", busy, 1);
    @(negedge clk);
    chk("shl_s3", valor, 8'h2F);
    chk("shl_busy3", busy, 0);
    chk("shl_done", done, 1);
    chk("shl_sout", serial_out, 1);
    @(negedge clk);
    chk("shl_done_drop", done, 0);
    // LOAD 0x90 then ASR by 2
    issue(3'd2, 4'd0, 8'h90, 1'b0);
    chk("load90", valor, 8'h90);
    issue(3'd7, 4'd2, 8'h00, 1'b1);
    chk("asr_s1", valor, 8'hC8);
    chk("asr_busy", busy, 1);
    @(negedge clk);
    chk("asr_s2", valor, 8'hE4);
    chk("asr_done", done, 1);
    chk("asr_sout", serial_out, 0);
    // LOAD 0x01 then ROR by 9, CLEAR held during busy
    issue(3'd2, 4'd0, 8'h01, 1'b0);
    chk("load01", valor, 8'h01);
    issue(3'd6, 4'd9, 8'h00, 1'b0);
    chk("ror_s1", valor, 8'h80);
    funcao = 3'd1; quant = 4'd0; cmd_valid = 1'b1;
    for (int k = 2; k <= 8; k++) begin
      @(negedge clk);
      exp_v = 8'h80 >> (k - 1);
      chk($sformatf("ror_s%0d", k), valor, exp_v);
      chk($sformatf("ror_busy%0d", k), busy, 1);
    end
    @(negedge clk);
    chk("ror_final", valor, 8'h80);
    chk("ror_done", done, 1);
    chk("ror_ready", cmd_ready, 1);
    chk("ror_sout", serial_out, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("clr_b2b_valor", valor, 8'h00);
    chk("clr_b2b_done", done, 1);
    // SHR by 0, HOLD, CLEAR
    issue(3'd2, 4'd0, 8'hFF, 1'b0);
    chk("loadff", valor, 8'hFF);
    issue(3'd4, 4'd0, 8'h00, 1'b0);
    chk("shr0_valor", valor, 8'hFF);
    chk("shr0_done", done, 1);
    chk("shr0_busy", busy, 0);
    @(negedge clk);
    chk("shr0_done_drop", done, 0);
    issue(3'd0, 4'd5, 8'h12, 1'b1);
    chk("hold_valor", valor, 8'hFF);
    chk("hold_done", done, 1);
    issue(3'd1, 4'd0, 8'h00, 1'b0);
    chk("clear_valor", valor, 8'h00);
    // Reset mid-shift
    issue(3'd2, 4'd0, 8'hFF, 1'b0);
    issue(3'd3, 4'd5, 8'h00, 1'b0);
    chk("mid_s1", valor, 8'hFE);
    chk("mid_sout1", serial_out, 1);
    @(negedge clk);
    chk("mid_s2", valor, 8'hFC);
    #1 reset_n = 1'b0;
    #1;
    chk("arst_valor", valor, 8'h00);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_sout", serial_out, 0);
    @(negedge clk);
    reset_n = 1'b1;
    issue(3'd2, 4'd0, 8'h3C, 1'b0);
    chk("post_load", valor, 8'h3C);
    chk("post_done", done, 1);
    chk("post_busy", busy, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
